// File: rtl/scan_pq_pkg.sv
// Shared types for the scan-based priority queue: entry layout and scan FSM states.
package scan_pq_pkg;

  localparam int unsigned KEY_W = 8;
  localparam int unsigned VAL_W = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] value;
  } kv_t;

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } scan_state_e;

endpackage

// File: rtl/scan_pq.sv
// Unsorted-array priority queue: one-cycle enqueue, dequeue/replace followed by a
// linear scan (one slot per cycle) that re-establishes the minimum-key head.
module scan_pq
  import scan_pq_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  kv_t  kvi,
  input  logic enq,
  input  logic deq,
  output kv_t  kvo,
  output logic full,
  output logic empty,
  output logic busy
);

  localparam int unsigned   IW       = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  kv_t           mem_q [DEPTH];
  kv_t           mem_d [DEPTH];
  scan_state_e   state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] head_idx_q, head_idx_d;
  logic [IW-1:0] scan_idx_q, scan_idx_d;
  logic [IW-1:0] best_idx_q, best_idx_d;
  kv_t           kvo_q, kvo_d;
  kv_t           best_kv_q, best_kv_d;
  kv_t           cand;
  logic          full_w, empty_w;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);
  assign full    = full_w;
  assign empty   = empty_w;
  assign busy    = (state_q == S_SCAN);
  assign kvo     = kvo_q;

  always_comb begin
    mem_d      = mem_q;
    state_d    = state_q;
    count_d    = count_q;
    head_idx_d = head_idx_q;
    scan_idx_d = scan_idx_q;
    best_idx_d = best_idx_q;
    best_kv_d  = best_kv_q;
    kvo_d      = kvo_q;
    cand       = mem_q[scan_idx_q];

    unique case (state_q)
      S_IDLE: begin
        // enq+deq on an empty queue degrades to a plain enqueue
        if (enq && (!deq || empty_w)) begin
          if (!full_w) begin
            mem_d[IW'(count_q)] = kvi;
            count_d             = count_q + CNT_ONE;
            if (empty_w || (kvi.key < kvo_q.key)) begin
              head_idx_d = IW'(count_q);
              kvo_d      = kvi;
            end
          end
        end else if (deq && !empty_w) begin
          if (enq) begin
            mem_d[head_idx_q] = kvi;
          end else begin
            mem_d[head_idx_q] = mem_q[IW'(count_q - CNT_ONE)];
            count_d           = count_q - CNT_ONE;
          end
          if (count_d == '0) begin
            kvo_d = '0;
          end else begin
            state_d    = S_SCAN;
            scan_idx_d = '0;
          end
        end
      end

      S_SCAN: begin
        // slot 0 seeds the running minimum; strict compare keeps the lowest index on ties
        if ((scan_idx_q == '0) || (cand.key < best_kv_q.key)) begin
          best_idx_d = scan_idx_q;
          best_kv_d  = cand;
        end
        if (CW'(scan_idx_q) == (count_q - CNT_ONE)) begin
          head_idx_d = best_idx_d;
          kvo_d      = best_kv_d;
          state_d    = S_IDLE;
        end else begin
          scan_idx_d = scan_idx_q + IW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      head_idx_q <= '0;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_kv_q  <= '0;
      kvo_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_idx_q <= head_idx_d;
      scan_idx_q <= scan_idx_d;
      best_idx_q <= best_idx_d;
      best_kv_q  <= best_kv_d;
      kvo_q      <= kvo_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_scan_pq.sv
// Directed bench for scan_pq: slot-level reference model checked every cycle, plus literal pins.
module tb_scan_pq;
  import scan_pq_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst, enq, deq;
  kv_t  kvi, kvo;
  logic full, empty, busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  scan_pq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .kvi(kvi), .enq(enq), .deq(deq),
    .kvo(kvo), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: slot contents, occupancy, published head, remaining busy cycles.
  logic [15:0] m_mem [DEPTH];
  int          m_cnt  = 0;
  int          m_head = 0;
  logic [15:0] m_kvo  = '0;
  int          m_busy = 0;
  int          p_head = 0;
  logic [15:0] p_kvo  = '0;
  bit          chk_en = 1'b0;

  function automatic int min_slot(int cnt);
    int best = 0;
    for (int i = 1; i < cnt; i++)
      if (m_mem[i][15:8] < m_mem[best][15:8]) best = i;
    return best;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_cnt = 0; m_head = 0; m_kvo = '0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_head = p_head; m_kvo = p_kvo; end
    end else if (enq && (!deq || m_cnt == 0)) begin
      if (m_cnt < DEPTH) begin
        m_mem[m_cnt] = kvi;
        if (m_cnt == 0 || kvi[15:8] < m_kvo[15:8]) begin m_head = m_cnt; m_kvo = kvi; end
        m_cnt++;
      end
    end else if (deq && m_cnt > 0) begin
      if (enq) m_mem[m_head] = kvi;
      else begin m_mem[m_head] = m_mem[m_cnt-1]; m_cnt--; end
      if (m_cnt == 0) m_kvo = '0;
      else begin
        m_busy = m_cnt;
        p_head = min_slot(m_cnt);
        p_kvo  = m_mem[p_head];
      end
    end
  endtask

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_busy",  16'(busy),  16'(m_busy > 0));
      check("m_empty", 16'(empty), 16'(m_cnt == 0));
      check("m_full",  16'(full),  16'(m_cnt == DEPTH));
      if (m_busy == 0 && m_cnt > 0) check("m_kvo", kvo, m_kvo);
      if (m_cnt == 0) check("m_kvo0", kvo, 16'h0000);
    end
  end

  task automatic cyc(bit e, bit d, logic [15:0] k, bit r = 1'b1);
    enq = e; deq = d; kvi = k; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    enq = 1'b0; deq = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin cyc(1'b0, 1'b0, 16'h0000); n++; end
    check("idle_timeout", 16'(busy), 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    enq = 0; deq = 0; kvi = '0; rst = 0;
    // reset with enq held high must store nothing
    cyc(1, 0, 16'h0501, 0);
    chk_en = 1'b1;
    cyc(1, 0, 16'h0501, 0);
    check("rst_empty", 16'(empty), 16'h0001);
    check("rst_full",  16'(full),  16'h0000);
    check("rst_busy",  16'(busy),  16'h0000);
    check("rst_kvo",   kvo,        16'h0000);
    cyc(0, 0, 16'h0000);
    check("rst_nothing_stored", 16'(empty), 16'h0001);

    // enqueue order
    cyc(1, 0, 16'h1EA1); check("enq1", kvo, 16'h1EA1);
    cyc(1, 0, 16'h0AA2); check("enq2", kvo, 16'h0AA2);
    cyc(1, 0, 16'h14A3); check("enq3", kvo, 16'h0AA2);
    check("enq_busy", 16'(busy), 16'h0000);

    // dequeue head: busy exactly 2 cycles
    cyc(0, 1, 16'h0000); check("deq_busy1", 16'(busy), 16'h0001);
    cyc(0, 0, 16'h0000); check("deq_busy2", 16'(busy), 16'h0001);
    cyc(0, 0, 16'h0000); check("deq_busy_end", 16'(busy), 16'h0000);
    check("deq_head1", kvo, 16'h14A3);
    cyc(0, 1, 16'h0000); wait_idle(20); check("deq_head2", kvo, 16'h1EA1);
    cyc(0, 1, 16'h0000);
    check("deq_last_empty", 16'(empty), 16'h0001);
    check("deq_last_kvo",   kvo,        16'h0000);
    check("deq_last_busy",  16'(busy),  16'h0000);

    // full boundary
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, {8'(8'h20 + i), 8'(i)});
    check("full_set", 16'(full), 16'h0001);
    check("full_head", kvo, 16'h2000);
    cyc(1, 0, 16'h00FF);
    check("full_drop_kvo",  kvo,        16'h2000);
    check("full_drop_full", 16'(full),  16'h0001);
    cyc(0, 1, 16'h0000);
    check("full_clear", 16'(full), 16'h0000);
    wait_idle(40);
    check("full_next_head", kvo, 16'h2101);
    while (!empty) begin cyc(0, 1, 16'h0000); wait_idle(40); end

    // replace and ties; requests during busy are dropped
    cyc(1, 0, 16'h05AA);
    cyc(1, 0, 16'h09BB);
    cyc(1, 1, 16'h05CC); check("rep_busy1", 16'(busy), 16'h0001);
    cyc(1, 0, 16'h0011); check("rep_busy2", 16'(busy), 16'h0001);
    cyc(0, 1, 16'h0000); check("rep_busy_end", 16'(busy), 16'h0000);
    check("rep_head", kvo, 16'h05CC);
    cyc(1, 0, 16'h05EE); check("tie_enq_no_steal", kvo, 16'h05CC);
    cyc(1, 1, 16'h05FF); wait_idle(20);
    check("tie_slot0_wins", kvo, 16'h05FF);

    // reset on the second busy cycle
    cyc(0, 1, 16'h0000); check("mid_busy1", 16'(busy), 16'h0001);
    cyc(0, 0, 16'h0000, 0);
    check("mid_rst_busy",  16'(busy),  16'h0000);
    check("mid_rst_empty", 16'(empty), 16'h0001);
    check("mid_rst_kvo",   kvo,        16'h0000);
    cyc(1, 0, 16'h4242); check("post_rst_enq", kvo, 16'h4242);
    cyc(0, 0, 16'h0000);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
